// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for one shared 4:1 single-bit mux.
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req[3:0]      request per requester, held high while access is wanted
//   done[3:0]     release strobe; only the current owner's bit matters
//   grant[3:0]    registered one-hot owner, zero when idle
//   sel[1:0]      registered owner index (drives mux s); holds when idle
//   mux_en, busy  both equal |grant (mux_en drives mux en)
//   timeout       one-cycle pulse after a grant is revoked for reaching MAX_HOLD
//
// mux4_rr_lane: per-requester priority distance from the round-robin pointer.
//   last_i        index of the most recent winner
//   req_i         this lane's request
//   dist_o        scan position (0 = highest priority) relative to last_i
//   vld_o         lane is a candidate this cycle

module mux4_rr_lane #(
  parameter int unsigned      IW  = 2,
  parameter logic [IW-1:0]    IDX = '0
) (
  input  logic [IW-1:0] last_i,
  input  logic          req_i,
  output logic [IW-1:0] dist_o,
  output logic          vld_o
);
  // Scan starts at last+1; modular wrap comes from the IW-bit width.
  assign dist_o = IDX - last_i - IW'(1);
  assign vld_o  = req_i;
endmodule

module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       mux_en,
  output logic       busy,
  output logic       timeout
);
  localparam int unsigned   NUM_LANES = 4;
  localparam int unsigned   IW        = 2;
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   grant_q, grant_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_LANES-1:0][IW-1:0] lane_dist;
  logic [NUM_LANES-1:0]         lane_vld;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      mux4_rr_lane #(.IW(IW), .IDX(IW'(g))) u_lane (
        .last_i (last_q),
        .req_i  (req[g]),
        .dist_o (lane_dist[g]),
        .vld_o  (lane_vld[g])
      );
    end
  endgenerate

  // Winner = requesting lane with the smallest scan distance (distances are unique).
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_dist;

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_dist = '1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_vld[i] && (!win_vld || lane_dist[i] < win_dist)) begin
        win_vld  = 1'b1;
        win_idx  = IW'(i);
        win_dist = lane_dist[i];
      end
    end
  end

  // Release reasons for the current owner; done/drop outrank the hold limit.
  logic rel_done, rel_drop, rel_to, rel_any;
  assign rel_done = done[sel_q];
  assign rel_drop = !req[sel_q];
  assign rel_to   = (cnt_q == HOLD_MAX) && !rel_done && !rel_drop;
  assign rel_any  = rel_done || rel_drop || rel_to;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = OWN;
          grant_d = NUM_LANES'(1) << win_idx;
          sel_d   = win_idx;
          last_d  = win_idx;
          cnt_d   = CW'(1);
        end
      end
      OWN: begin
        if (rel_any) begin
          timeout_d = rel_to;
          // last_q already equals the owner, so it scans last; a lone
          // requester that timed out wins again here.
          if (win_vld) begin
            grant_d = NUM_LANES'(1) << win_idx;
            sel_d   = win_idx;
            last_d  = win_idx;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= IW'(NUM_LANES - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign mux_en  = |grant_q;
  assign busy    = |grant_q;
  assign timeout = timeout_q;
endmodule
